// File: rtl/frame_timer_ctrl.sv
// Bit-period / bit-count sequencer for serial frames: one shift strobe per bit period,
// then a single-cycle frame_done. Tick counter runs 1..ticks_l and rolls back to 1.
module frame_timer_ctrl #(
    parameter int unsigned TICK_BITS = 4,
    parameter int unsigned BIT_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TICK_BITS-1:0] ticks_per_bit,
    input  logic [BIT_BITS-1:0]  bits_per_frame,
    output logic                 busy,
    output logic                 shift_strobe,
    output logic                 frame_done,
    output logic                 cfg_err,
    output logic [TICK_BITS-1:0] tick_count,
    output logic [BIT_BITS-1:0]  bit_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [TICK_BITS-1:0] TickOne = TICK_BITS'(1);
    localparam logic [BIT_BITS-1:0]  BitOne  = BIT_BITS'(1);

    state_e                state_q, state_d;
    logic [TICK_BITS-1:0]  tick_q, tick_d;
    logic [BIT_BITS-1:0]   bit_q, bit_d;
    logic [TICK_BITS-1:0]  ticks_l_q, ticks_l_d;
    logic [BIT_BITS-1:0]   bits_l_q, bits_l_d;
    logic                  cfg_err_q, cfg_err_d;

    logic strobe;
    logic last_bit;
    logic cfg_ok;

    assign strobe   = (state_q == StRun) && (tick_q == ticks_l_q);
    assign last_bit = (bit_q == (bits_l_q - BitOne));
    assign cfg_ok   = (ticks_per_bit != '0) && (bits_per_frame != '0);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        ticks_l_d = ticks_l_q;
        bits_l_d  = bits_l_q;
        cfg_err_d = 1'b0;

        if (abort) begin
            // abort wins over start and over the DONE->IDLE step alike
            state_d = StIdle;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state_d   = StRun;
                            ticks_l_d = ticks_per_bit;
                            bits_l_d  = bits_per_frame;
                            tick_d    = TickOne;
                            bit_d     = '0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (strobe) begin
                        if (last_bit) begin
                            state_d = StDone;
                            tick_d  = '0;
                            bit_d   = bits_l_q;
                        end else begin
                            tick_d = TickOne;
                            bit_d  = bit_q + BitOne;
                        end
                    end else begin
                        tick_d = tick_q + TickOne;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    bit_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            ticks_l_q <= '0;
            bits_l_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            ticks_l_q <= ticks_l_d;
            bits_l_q  <= bits_l_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // All outputs decode registers only, so reset clears them without waiting for an edge
    assign busy         = (state_q != StIdle);
    assign shift_strobe = strobe;
    assign frame_done   = (state_q == StDone);
    assign cfg_err      = cfg_err_q;
    assign tick_count   = tick_q;
    assign bit_count    = bit_q;

endmodule
